// File: rtl/cpu_defs.sv
// Shared definitions for the data-side memory access path.
// Holds the MEM-stage access type encodings, the bus size codes, the access
// controller state encoding and a helper mapping an access type to a bus size.
package cpu_defs;

  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_BU = 3'b001;
  localparam logic [2:0] MT_H  = 3'b010;
  localparam logic [2:0] MT_HU = 3'b011;
  localparam logic [2:0] MT_W  = 3'b100;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mac_state_e;

  // Unused type codes fall into the word class so they are alignment-checked
  // as strictly as possible.
  function automatic logic [1:0] type_to_size(input logic [2:0] mt);
    if (mt[2])      return SZ_W;
    else if (mt[1]) return SZ_H;
    else            return SZ_B;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load result alignment: selects the addressed byte/half lane from a 32-bit
// bus word and sign- or zero-extends it according to the access type.
// Ports:
//   rdata  - raw bus read data
//   addr   - low two bits of the access address
//   mtype  - MEM-stage access type (MT_*)
//   result - aligned, extended load value
module load_align
  import cpu_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        mtype,
  output logic [DATA_W-1:0] result
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [DATA_W-1:0] v;
    v = {{(DATA_W-8){b[7] & sgn}}, b};
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [DATA_W-1:0] v;
    v = {{(DATA_W-16){h[15] & sgn}}, h};
    return v;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (mtype)
      MT_B, MT_BU: result = ext_byte(byte_sel, mtype == MT_B);
      MT_H, MT_HU: result = ext_half(half_sel, mtype == MT_H);
      default:     result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller between the MEM stage and the data bus bridge.
// Issues one req/addr_ok + data_ok bus transaction per accepted load/store,
// stalls the pipeline until the data returns, flags misaligned addresses and
// delivers the aligned, extended load result.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   mem_en/mem_wr/mem_type    - MEM-stage access request and kind
//   mem_addr/mem_wdata        - effective address and store data
//   flush                     - kill of the current MEM instruction
//   stall_in                  - downstream stall, result must be held
//   stall_out                 - stall request to the pipeline
//   rdata_out                 - aligned, extended load result
//   adel/ades                 - load/store address error
//   data_*                    - SRAM-like bus (req/addr_ok, data_ok)
module mem_access_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [2:0]        mem_type,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  input  logic              stall_in,
  output logic              stall_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              adel,
  output logic              ades,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  mac_state_e        state_q, state_d;
  logic              killed;
  logic [2:0]        type_r;
  logic [1:0]        acc_size;
  logic              misaligned;
  logic              accept;
  logic              data_done;
  logic              kill_eff;
  logic              capture;
  logic [ADDR_W-1:0] addr_fmt;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] load_word;

  assign acc_size   = type_to_size(mem_type);
  assign misaligned = mem_en && ((acc_size == SZ_H && mem_addr[0]) ||
                                 (acc_size == SZ_W && mem_addr[1:0] != 2'b00));
  assign adel       = misaligned && !mem_wr;
  assign ades       = misaligned && mem_wr;

  assign accept = (state_q == IDLE) && mem_en && !misaligned && !flush && !stall_in;

  // The data_ok beat may arrive together with addr_ok while still in REQ.
  assign data_done = ((state_q == WAIT) && data_data_ok) ||
                     ((state_q == REQ) && data_addr_ok && data_data_ok);
  // A flush coinciding with data_ok still discards the returning data.
  assign kill_eff  = killed || flush;
  assign capture   = data_done && !kill_eff && !data_wr;

  assign data_req  = (state_q == REQ);
  assign stall_out = accept || (state_q == REQ) || (state_q == WAIT);

  always_comb begin
    addr_fmt  = mem_addr;
    wdata_rep = mem_wdata;
    case (acc_size)
      SZ_B: wdata_rep = {4{mem_wdata[7:0]}};
      SZ_H: wdata_rep = {2{mem_wdata[15:0]}};
      default: begin
        wdata_rep = mem_wdata;
        addr_fmt  = {mem_addr[ADDR_W-1:2], 2'b00};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) state_d = kill_eff ? IDLE : DONE;
          else              state_d = WAIT;
        end
      end
      WAIT: if (data_data_ok) state_d = kill_eff ? IDLE : DONE;
      DONE: if (!stall_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata  (data_rdata),
    .addr   (data_addr[1:0]),
    .mtype  (type_r),
    .result (load_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      killed     <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= SZ_B;
      data_addr  <= '0;
      data_wdata <= '0;
      type_r     <= MT_B;
      rdata_out  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != IDLE && state_d == IDLE)
        killed <= 1'b0;
      else if ((state_q == REQ || state_q == WAIT) && flush)
        killed <= 1'b1;
      // Request stage: capture the access once, hold it for the whole transaction
      if (accept) begin
        data_wr    <= mem_wr;
        data_size  <= acc_size;
        data_addr  <= addr_fmt;
        data_wdata <= wdata_rep;
        type_r     <= mem_type;
      end
      // Response stage: aligned load data lands in the result register
      if (capture) rdata_out <= load_word;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences one data-memory access per MEM-stage instruction over a SRAM-like handshake bus: req/addr_ok, then data_ok.
- Generates the bus size and write data, and detects address-alignment exceptions.
- Stalls the pipeline until the data returns, then aligns and sign/zero-extends the load result.
- Sits between the MEM stage and the data-side bus bridge.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; byte lanes assume 4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_en  in  1  MEM stage holds a valid load/store
- mem_wr  in  1  1=store, 0=load
- mem_type  in  3  000 byte signed, 001 byte unsigned, 010 half signed, 011 half unsigned, 100 word
- mem_addr  in  32  effective address
- mem_wdata  in  32  store data (rt)
- flush  in  1  exception/eret kill of current MEM instruction
- stall_in  in  1  downstream stall; result must be held
- stall_out  out  1  stall request to pipeline
- rdata_out  out  32  aligned, extended load result
- adel  out  1  load address error
- ades  out  1  store address error
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data returned / write done
- data_rdata  in  32  bus read data

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, rdata_out=0, killed=0.
- Misalignment (combinational, gated by mem_en):
  - Half access with addr[0]!=0 is misaligned; word access with addr[1:0]!=0 is misaligned.
  - adel = misaligned & !mem_wr; ades = misaligned & mem_wr.
  - No bus access is issued for a misaligned access.
- IDLE:
  - Accept when mem_en & !misaligned & !flush & !stall_in.
  - On accept, register wr, size, addr, type, wdata; next state REQ.
  - Registered addr is word-aligned for word accesses; byte/half addresses pass through unchanged.
  - Store write data is replicated across lanes: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word unchanged.
- REQ:
  - data_req=1; bus outputs held stable.
  - On data_addr_ok, data_req drops the next cycle and state goes to WAIT.
  - data_req is never withdrawn before addr_ok, even on flush.
- WAIT:
  - On data_data_ok: if killed → IDLE.
  - Otherwise a load captures the aligned/extended data into rdata_out, and state goes to DONE.
  - data_addr_ok and data_data_ok in the same cycle while in REQ: go straight to the data_ok handling above.
- DONE:
  - rdata_out held; stall_out=0.
  - Return to IDLE when !stall_in.
  - mem_en in the DONE cycle refers to the already-completed instruction and is not re-accepted.
- stall_out:
  - 1 in the IDLE accept cycle, in REQ, and in WAIT.
  - 0 in IDLE without accept, and in DONE.
  - Stays 1 while killed until data_ok arrives, so no second request overlaps an outstanding one.
- Flush:
  - flush in REQ or WAIT sets killed; the bus transaction completes and its data is discarded.
  - killed clears on entry to IDLE.
  - flush in IDLE blocks acceptance.
- Load alignment:
  - Byte: lane addr[1:0] (00 → [7:0] … 11 → [31:24]), extended to 32 bits by mem_type (signed or unsigned).
  - Half: addr[1] selects [15:0] or [31:16], then extended.
  - Word: data passes through.
- Latency: minimum 3 cycles from accept to DONE, with addr_ok and data_ok each arriving in the first cycle possible.
- rst mid-transaction: state returns to IDLE immediately. The bridge is reset by the same rst, so no outstanding data_ok is tracked.

Decomposition:
- Shared package (cpu_defs):
  - mem_type encodings (MT_B, MT_BU, MT_H, MT_HU, MT_W).
  - Bus size codes (SZ_B=0, SZ_H=1, SZ_W=2).
  - State encodings (IDLE, REQ, WAIT, DONE).
- Sub-module load_align: purely combinational; inputs rdata, addr[1:0], type; output is the extended 32-bit word. It is unit-tested separately.

Test Plan:
- LB at addr 0x1003, data_rdata=0x80FF_1234, addr_ok at +1, data_ok at +2 → data_size=0, rdata_out=0xFFFF_FF80, stall_out high for exactly 3 cycles.
- LHU at 0x2002 with rdata 0xBEEF_0001 → rdata_out=0x0000_BEEF. Repeat as LH → 0xFFFF_BEEF.
- SB at 0x3001, wdata 0x1234_56AB → data_wr=1, data_size=0, data_wdata=0xABAB_ABAB; rdata_out unchanged.
- LW at 0x4002 → adel=1, data_req stays 0, stall_out=0. Repeat as SH at 0x4001 → ades=1.
- LW with addr_ok delayed 4 cycles and flush pulsed during REQ → data_req held until addr_ok. After data_ok: IDLE, rdata_out unchanged, no DONE state.
- LW completes while stall_in=1 for 3 cycles → DONE held with rdata_out stable. Back-to-back loads issue only after stall_in falls, never two outstanding requests.
